node_tx_queue: RTL and testbench

Packet queue between a processor node and its `router_core`. It buffers up to `DEPTH` 29-bit node packets, presents the oldest one on `Packet_From_Node` / `Packet_From_Node_Valid`, and retires it when the core pulses `Core_Load_Ack`. The node can therefore keep issuing packets while the core waits for the token. It also rejects packets addressed to the local router and counts every dropped packet.

---
 rtl/router_pkg.sv | 24 ++
 rtl/node_tx_queue_if.sv | 53 +++++
 rtl/pkt_fifo_mem.sv | 46 ++++
 rtl/node_tx_queue.sv | 75 +++++++
 tb/tb_node_tx_queue.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared packet definitions for the node/router path.
package router_pkg;

    localparam int ADDR_W    = 4;
    localparam int PAYLOAD_W = 24;
    localparam int PKT_W     = ADDR_W + 1 + PAYLOAD_W;

    localparam int DEST_MSB  = 28;
    localparam int DEST_LSB  = 25;
    localparam int TYPE_BIT  = 24;

    // Packet layout shared with router_core: {dest, type, payload}.
    typedef struct packed {
        logic [ADDR_W-1:0]    dest;
        logic                 typ;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

    // Destination field of a raw packet word.
    function automatic logic [ADDR_W-1:0] pkt_dest(input logic [PKT_W-1:0] pkt);
        return pkt[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/node_tx_queue_if.sv
// Node-side and core-side signals of the node transmit queue.
// Handshake: a push happens at a rising edge where Node_Packet_Valid is high;
// it is accepted only while Node_Packet_Ready is high and dest != r_addr,
// otherwise it is dropped and counted. A pop happens at a rising edge where
// Core_Load_Ack and Packet_From_Node_Valid are both high; Packet_From_Node
// holds while Valid is high and no pop occurs.
interface node_tx_queue_if
    import router_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_addr;
    logic [PKT_W-1:0]  Node_Packet;
    logic              Node_Packet_Valid;
    logic              Node_Packet_Ready;
    logic [PKT_W-1:0]  Packet_From_Node;
    logic              Packet_From_Node_Valid;
    logic              Core_Load_Ack;
    logic [CNT_W-1:0]  Count;
    logic              Overflow;
    logic [7:0]        Drop_Count;

    // Node/core side: drives requests, observes queue state.
    modport master (
        output r_addr,
        output Node_Packet,
        output Node_Packet_Valid,
        output Core_Load_Ack,
        input  Node_Packet_Ready,
        input  Packet_From_Node,
        input  Packet_From_Node_Valid,
        input  Count,
        input  Overflow,
        input  Drop_Count
    );

    // Queue side.
    modport slave (
        input  r_addr,
        input  Node_Packet,
        input  Node_Packet_Valid,
        input  Core_Load_Ack,
        output Node_Packet_Ready,
        output Packet_From_Node,
        output Packet_From_Node_Valid,
        output Count,
        output Overflow,
        output Drop_Count
    );

endinterface

// File: rtl/pkt_fifo_mem.sv
// Circular register array with write/read pointers and no flags.
// The caller decides when a push or pop is legal.
module pkt_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 29
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Pointer next state; wrap is free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/node_tx_queue.sv
// Node transmit queue: buffers node packets until router_core acks them,
// rejecting self-addressed packets and counting every drop.
module node_tx_queue
    import router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  Clk_R,
    input  logic                  Rst,
    node_tx_queue_if.slave        bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_q, drop_d;

    logic full, empty, self_addr;
    logic push_ok, pop_ok, drop;

    // Accept/drop decisions; full and empty come from the count register only.
    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        self_addr = (pkt_dest(bus.Node_Packet) == bus.r_addr);
        push_ok   = bus.Node_Packet_Valid && !full && !self_addr;
        pop_ok    = bus.Core_Load_Ack && !empty;
        drop      = bus.Node_Packet_Valid && (full || self_addr);
    end

    // Occupancy and drop bookkeeping next state.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
        // A full queue rejects even when a pop frees a slot this cycle.
        if (bus.Node_Packet_Valid && full) overflow_d = 1'b1;
        if (drop && drop_q != 8'hFF)       drop_d = drop_q + 8'd1;
    end

    // Count and sticky flags, cleared asynchronously.
    always_ff @(posedge Clk_R or posedge Rst) begin
        if (Rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    pkt_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (PKT_W)
    ) u_mem (
        .clk_i   (Clk_R),
        .rst_i   (Rst),
        .push_i  (push_ok),
        .pop_i   (pop_ok),
        .wdata_i (bus.Node_Packet),
        .rdata_o (bus.Packet_From_Node)
    );

    assign bus.Node_Packet_Ready      = !full;
    assign bus.Packet_From_Node_Valid = !empty;
    assign bus.Count                  = count_q;
    assign bus.Overflow               = overflow_q;
    assign bus.Drop_Count             = drop_q;

endmodule

// File: tb/tb_node_tx_queue.sv
// Directed bench for node_tx_queue with hand-computed expectations.
module tb_node_tx_queue;
    import router_pkg::*;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    logic [PKT_W-1:0] exp_q[$];

    node_tx_queue_if #(.DEPTH(4)) bus();

    node_tx_queue #(.DEPTH(4)) u_dut (
        .Clk_R (clk),
        .Rst   (rst),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk(input logic [3:0] d, input logic t, input logic [23:0] p);
        return {d, t, p};
    endfunction

    // Drivers: inputs set between edges, outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PKT_W-1:0] pkt, input logic ack);
        bus.Node_Packet_Valid = v;
        bus.Node_Packet       = pkt;
        bus.Core_Load_Ack     = ack;
        step();
        bus.Node_Packet_Valid = 1'b0;
        bus.Core_Load_Ack     = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic [PKT_W-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(bus.Packet_From_Node_Valid), 32'd1);
            check({tag, "_pkt"}, 32'(bus.Packet_From_Node), 32'(e));
            drive(1'b0, '0, 1'b1);
        end
        check({tag, "_empty"}, 32'(bus.Packet_From_Node_Valid), 32'd0);
        check({tag, "_cnt0"}, 32'(bus.Count), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.r_addr            = 4'd0;
        bus.Node_Packet       = '0;
        bus.Node_Packet_Valid = 1'b0;
        bus.Core_Load_Ack     = 1'b0;

        // Reset state
        #12;
        check("rst_ready", 32'(bus.Node_Packet_Ready), 32'd1);
        check("rst_valid", 32'(bus.Packet_From_Node_Valid), 32'd0);
        check("rst_count", 32'(bus.Count), 32'd0);
        check("rst_ovf",   32'(bus.Overflow), 32'd0);
        check("rst_drop",  32'(bus.Drop_Count), 32'd0);
        rst = 1'b0;
        step();

        // Single packet
        drive(1'b1, mk(4'd1, 1'b0, 24'd42), 1'b0);
        check("single_valid", 32'(bus.Packet_From_Node_Valid), 32'd1);
        check("single_pkt",   32'(bus.Packet_From_Node), 32'h200002A);
        check("single_cnt",   32'(bus.Count), 32'd1);
        drive(1'b0, '0, 1'b1);
        check("single_popv",  32'(bus.Packet_From_Node_Valid), 32'd0);
        check("single_popc",  32'(bus.Count), 32'd0);

        // Ack on an empty queue is ignored
        drive(1'b0, '0, 1'b1);
        check("eack_cnt",  32'(bus.Count), 32'd0);
        check("eack_rdy",  32'(bus.Node_Packet_Ready), 32'd1);

        // Overflow: payload 44 carries type=1 to check passthrough
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(4'd1, (i == 2), 24'(42 + i)), 1'b0);
            exp_q.push_back(mk(4'd1, (i == 2), 24'(42 + i)));
        end
        check("full_ready", 32'(bus.Node_Packet_Ready), 32'd0);
        check("full_cnt",   32'(bus.Count), 32'd4);
        check("full_ovf0",  32'(bus.Overflow), 32'd0);
        drive(1'b1, mk(4'd1, 1'b0, 24'd46), 1'b0);
        check("ovf_flag",   32'(bus.Overflow), 32'd1);
        check("ovf_drop",   32'(bus.Drop_Count), 32'd1);
        check("ovf_cnt",    32'(bus.Count), 32'd4);
        check("ovf_head",   32'(bus.Packet_From_Node), 32'(mk(4'd1, 1'b0, 24'd42)));
        // Push while full with a pop in the same cycle is still dropped
        drive(1'b1, mk(4'd1, 1'b0, 24'd47), 1'b1);
        void'(exp_q.pop_front());
        check("fullpop_cnt",  32'(bus.Count), 32'd3);
        check("fullpop_drop", 32'(bus.Drop_Count), 32'd2);
        drain("ovf_drain");

        // Simultaneous push and pop at Count=2
        drive(1'b1, mk(4'd3, 1'b0, 24'd50), 1'b0);
        drive(1'b1, mk(4'd3, 1'b0, 24'd51), 1'b0);
        exp_q.push_back(mk(4'd3, 1'b0, 24'd50));
        exp_q.push_back(mk(4'd3, 1'b0, 24'd51));
        drive(1'b0, '0, 1'b0);
        check("hold_head", 32'(bus.Packet_From_Node), 32'(mk(4'd3, 1'b0, 24'd50)));
        check("sim_pre",   32'(bus.Count), 32'd2);
        drive(1'b1, mk(4'd3, 1'b0, 24'd52), 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(mk(4'd3, 1'b0, 24'd52));
        check("sim_cnt",  32'(bus.Count), 32'd2);
        check("sim_head", 32'(bus.Packet_From_Node), 32'(mk(4'd3, 1'b0, 24'd51)));
        drain("sim_drain");

        // Self-address, from a clean reset so Overflow starts at 0
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.r_addr = 4'd1;
        step();
        drive(1'b1, mk(4'd1, 1'b0, 24'd60), 1'b0);
        check("self_valid", 32'(bus.Packet_From_Node_Valid), 32'd0);
        check("self_drop",  32'(bus.Drop_Count), 32'd1);
        check("self_ovf",   32'(bus.Overflow), 32'd0);
        drive(1'b1, mk(4'd2, 1'b0, 24'd61), 1'b0);
        exp_q.push_back(mk(4'd2, 1'b0, 24'd61));
        check("other_cnt",  32'(bus.Count), 32'd1);
        drain("self_drain");

        // Drop_Count saturation
        for (int i = 0; i < 260; i++) drive(1'b1, mk(4'd1, 1'b0, 24'(i)), 1'b0);
        check("sat_drop", 32'(bus.Drop_Count), 32'd255);
        check("sat_ovf",  32'(bus.Overflow), 32'd0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) drive(1'b1, mk(4'd2, 1'b0, 24'(7 + i)), 1'b0);
        check("mid_pre", 32'(bus.Count), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        check("mid_valid", 32'(bus.Packet_From_Node_Valid), 32'd0);
        check("mid_count", 32'(bus.Count), 32'd0);
        check("mid_ready", 32'(bus.Node_Packet_Ready), 32'd1);
        check("mid_drop",  32'(bus.Drop_Count), 32'd0);
        #2;
        rst = 1'b0;
        drive(1'b1, mk(4'd2, 1'b0, 24'd100), 1'b0);
        exp_q.push_back(mk(4'd2, 1'b0, 24'd100));
        check("mid_new_cnt", 32'(bus.Count), 32'd1);
        drain("mid_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
